// File: rtl/fitness_eval_gen.sv
// Lattice fitness evaluator: per-individual energy from self and nearest-neighbour terms,
// with generation bookkeeping (accept count, in-order results, minimum-energy tracker).
module fitness_eval_gen #(
    parameter int NUM_PARTICLE_TYPE = 3,
    parameter int DATA_WIDTH        = 4,
    parameter int PARTICLE_LENGTH   = 2,
    parameter int LATTICE_LENGTH    = 11,
    parameter int SELF_FIT_LENGTH   = 10,
    parameter int POP_SIZE          = 50,
    parameter int IDX_WIDTH         = 6
) (
    input  logic                                                   clk_i,
    input  logic                                                   rst_i,
    input  logic                                                   set_data_i,
    input  logic [NUM_PARTICLE_TYPE*DATA_WIDTH-1:0]                self_energy_vec_i,
    input  logic [NUM_PARTICLE_TYPE*NUM_PARTICLE_TYPE*DATA_WIDTH-1:0] interact_matrix_i,
    input  logic                                                   periodic_i,
    input  logic                                                   in_valid_i,
    input  logic [LATTICE_LENGTH*PARTICLE_LENGTH-1:0]              individual_vec_i,
    input  logic [IDX_WIDTH-1:0]                                   ind_idx_i,
    output logic                                                   in_ready_o,
    output logic                                                   out_valid_ff_o,
    output logic [SELF_FIT_LENGTH-1:0]                             total_energy_ff_o,
    output logic [IDX_WIDTH-1:0]                                   ind_wb_idx_ff_o,
    output logic [SELF_FIT_LENGTH-1:0]                             best_energy_ff_o,
    output logic [IDX_WIDTH-1:0]                                   best_idx_ff_o,
    output logic                                                   done_ff_o,
    output logic                                                   code_err_ff_o
);

    localparam int NT    = NUM_PARTICLE_TYPE;
    localparam int DW    = DATA_WIDTH;
    localparam int PL    = PARTICLE_LENGTH;
    localparam int L     = LATTICE_LENGTH;
    localparam int FW    = SELF_FIT_LENGTH;
    localparam int MAX_E = 3 * L * ((1 << DW) - 1);
    localparam int SUM_W = $clog2(MAX_E + 1);
    localparam int TOT_W = ((SUM_W > FW) ? SUM_W : FW) + 1;
    localparam int CW    = $clog2(POP_SIZE + 1);

    localparam logic [CW-1:0]    POP    = CW'(POP_SIZE);
    localparam logic [CW-1:0]    LAST   = CW'(POP_SIZE - 1);
    localparam logic [TOT_W-1:0] FW_MAX = {{(TOT_W-FW){1'b0}}, {FW{1'b1}}};

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t state, state_next;
    logic   load, accept, bad_in;

    logic [NT*DW-1:0]    self_tbl;
    logic [NT*NT*DW-1:0] mat_tbl;
    logic                periodic;
    logic [CW-1:0]       acc_cnt, res_cnt;
    logic                best_first;

    logic                s0_v, s1_v, s2_v;
    logic [L*PL-1:0]     s0_ind;
    logic [IDX_WIDTH-1:0] s0_idx, s1_idx, s2_idx;
    logic [DW-1:0]       s1_self [L];
    logic [DW-1:0]       s1_pair [L];
    logic [SUM_W-1:0]    s2_self, s2_pair;

    logic [DW-1:0]       lk_self [L];
    logic [DW-1:0]       lk_pair [L];
    logic [SUM_W-1:0]    ps_self, ps_pair;
    logic [TOT_W-1:0]    tot;
    logic [FW-1:0]       energy;

    function automatic logic code_ok(input logic [PL-1:0] p);
        return int'(p) < NT;
    endfunction

    function automatic logic [DW-1:0] self_lookup(input logic [NT*DW-1:0] tbl,
                                                  input logic [PL-1:0] p);
        if (code_ok(p)) return tbl[(NT - 1 - int'(p)) * DW +: DW];
        return '0;
    endfunction

    // An illegal code on either end zeroes the whole pair term.
    function automatic logic [DW-1:0] pair_lookup(input logic [NT*NT*DW-1:0] tbl,
                                                  input logic [PL-1:0] a,
                                                  input logic [PL-1:0] b);
        if (code_ok(a) && code_ok(b))
            return tbl[(NT * NT - 1 - (int'(a) * NT + int'(b))) * DW +: DW];
        return '0;
    endfunction

    always_comb begin
        bad_in = 1'b0;
        for (int j = 0; j < L; j++) begin
            if (!code_ok(individual_vec_i[j*PL +: PL])) bad_in = 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        in_ready_o = 1'b0;
        load       = 1'b0;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (set_data_i) begin
                    load       = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                // A reload at the start of a generation takes priority over data.
                if (set_data_i && acc_cnt == '0) begin
                    load = 1'b1;
                end else begin
                    in_ready_o = 1'b1;
                    if (in_valid_i) begin
                        accept = 1'b1;
                        if (acc_cnt == LAST) state_next = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (res_cnt == POP) state_next = DONE;
            end
            DONE: begin
                state_next = RUN;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        for (int j = 0; j < L; j++) begin
            lk_self[j] = self_lookup(self_tbl, s0_ind[j*PL +: PL]);
        end
        lk_pair[0] = periodic ? pair_lookup(mat_tbl, s0_ind[(L-1)*PL +: PL], s0_ind[0 +: PL]) : '0;
        for (int j = 1; j < L; j++) begin
            lk_pair[j] = pair_lookup(mat_tbl, s0_ind[(j-1)*PL +: PL], s0_ind[j*PL +: PL]);
        end
    end

    always_comb begin
        ps_self = '0;
        ps_pair = '0;
        for (int j = 0; j < L; j++) begin
            ps_self = ps_self + SUM_W'(s1_self[j]);
            ps_pair = ps_pair + SUM_W'(s1_pair[j]);
        end
    end

    always_comb begin
        tot    = TOT_W'(s2_self) + (TOT_W'(s2_pair) << 1);
        energy = (tot > FW_MAX) ? '1 : tot[FW-1:0];
    end

    always_ff @(posedge clk_i) begin
        s0_ind <= individual_vec_i;
        s0_idx <= ind_idx_i;
        s1_idx <= s0_idx;
        s2_idx <= s1_idx;
        for (int j = 0; j < L; j++) begin
            s1_self[j] <= lk_self[j];
            s1_pair[j] <= lk_pair[j];
        end
        s2_self <= ps_self;
        s2_pair <= ps_pair;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state             <= IDLE;
            acc_cnt           <= '0;
            res_cnt           <= '0;
            self_tbl          <= '0;
            mat_tbl           <= '0;
            periodic          <= 1'b0;
            code_err_ff_o     <= 1'b0;
            s0_v              <= 1'b0;
            s1_v              <= 1'b0;
            s2_v              <= 1'b0;
            out_valid_ff_o    <= 1'b0;
            total_energy_ff_o <= '0;
            ind_wb_idx_ff_o   <= '0;
            best_energy_ff_o  <= '1;
            best_idx_ff_o     <= '0;
            best_first        <= 1'b1;
            done_ff_o         <= 1'b0;
        end else begin
            state          <= state_next;
            done_ff_o      <= (state_next == DONE);
            s0_v           <= accept;
            s1_v           <= s0_v;
            s2_v           <= s1_v;
            out_valid_ff_o <= s2_v;

            if (load) begin
                self_tbl      <= self_energy_vec_i;
                mat_tbl       <= interact_matrix_i;
                periodic      <= periodic_i;
                code_err_ff_o <= 1'b0;
            end else if (accept && bad_in) begin
                code_err_ff_o <= 1'b1;
            end

            if (accept) acc_cnt <= acc_cnt + CW'(1);

            // Best outputs stay visible across DONE until the next generation's first result.
            if (s2_v) begin
                total_energy_ff_o <= energy;
                ind_wb_idx_ff_o   <= s2_idx;
                res_cnt           <= res_cnt + CW'(1);
                best_first        <= 1'b0;
                if (best_first || energy < best_energy_ff_o) begin
                    best_energy_ff_o <= energy;
                    best_idx_ff_o    <= s2_idx;
                end
            end

            if (state == DONE) begin
                acc_cnt    <= '0;
                res_cnt    <= '0;
                best_first <= 1'b1;
            end
        end
    end

endmodule
